// File: rtl/rp_shutdown_ctrl.sv
// rtl/rp_shutdown_ctrl.sv - PRC shutdown handshake sequencer
// Drains outstanding AXI/DMA traffic, decouples and resets the partition, then re-activates it.
module rp_shutdown_ctrl #(
  parameter int RESET_CYCLES    = 16,
  parameter int MAX_OUTSTANDING = 16,
  parameter int DRAIN_TIMEOUT   = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic shutdown_req,
  output logic shutdown_ack,
  output logic active,
  output logic block_new,
  output logic decouple,
  output logic rp_rst_n,
  output logic drain_timeout,
  input  logic ar_hs,
  input  logic r_last_hs,
  input  logic aw_hs,
  input  logic b_hs,
  input  logic dma_tvalid,
  input  logic dma_tready,
  input  logic dma_tlast
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int HW = $clog2(RESET_CYCLES) + 1;
  localparam int TW = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_OUTSTANDING);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RESET_HOLD,
    S_ACTIVE,
    S_DRAIN,
    S_DECOUPLED
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] rd_out, wr_out;
  logic          dma_busy;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] to_cnt;
  logic          idle, timeout_hit;

  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] cnt,
                                             input logic inc, input logic dec);
    logic [CW-1:0] r;
    r = cnt;
    if (inc && !dec && cnt != CNT_MAX)
      r = cnt + CW'(1);
    else if (dec && !inc && cnt != '0)
      r = cnt - CW'(1);
    return r;
  endfunction

  // Traffic tracking runs in every state so a forced drain keeps its debt.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_out   <= '0;
      wr_out   <= '0;
      dma_busy <= 1'b0;
    end else begin
      rd_out <= sat_step(rd_out, ar_hs, r_last_hs);
      wr_out <= sat_step(wr_out, aw_hs, b_hs);
      if (dma_tvalid && dma_tready)
        dma_busy <= !dma_tlast;
    end
  end

  assign idle = (rd_out == '0) && (wr_out == '0) && !dma_busy;

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      S_RESET_HOLD: begin
        if (shutdown_req)
          state_nxt = S_DECOUPLED;
        else if (hold_cnt == HOLD_LAST)
          state_nxt = S_ACTIVE;
      end
      S_ACTIVE: if (shutdown_req) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (idle) begin
          state_nxt = S_DECOUPLED;
        end else if (to_cnt == TO_LAST) begin
          state_nxt   = S_DECOUPLED;
          timeout_hit = 1'b1;
        end
      end
      S_DECOUPLED: if (!shutdown_req) state_nxt = S_RESET_HOLD;
      default: state_nxt = S_RESET_HOLD;
    endcase
  end

  // Outputs are decoded from the next state so they change together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RESET_HOLD;
      hold_cnt      <= '0;
      to_cnt        <= '0;
      shutdown_ack  <= 1'b0;
      active        <= 1'b0;
      block_new     <= 1'b1;
      decouple      <= 1'b1;
      rp_rst_n      <= 1'b0;
      drain_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_RESET_HOLD)
        hold_cnt <= hold_cnt + HW'(1);
      else if (state == S_DECOUPLED && state_nxt == S_RESET_HOLD)
        hold_cnt <= '0;
      if (state == S_DRAIN)
        to_cnt <= to_cnt + TW'(1);
      else if (state == S_ACTIVE && state_nxt == S_DRAIN)
        to_cnt <= '0;
      if (state == S_ACTIVE && state_nxt == S_DRAIN)
        drain_timeout <= 1'b0;
      else if (timeout_hit)
        drain_timeout <= 1'b1;
      shutdown_ack <= (state_nxt == S_DECOUPLED);
      active       <= (state_nxt == S_ACTIVE);
      block_new    <= (state_nxt != S_ACTIVE);
      decouple     <= (state_nxt == S_RESET_HOLD) || (state_nxt == S_DECOUPLED);
      rp_rst_n     <= (state_nxt == S_ACTIVE) || (state_nxt == S_DRAIN);
    end
  end

endmodule
